// File: rtl/baser_257b_lock_ctrl.sv
// Block-lock controller for the 256B/257B receive path: hunts for lock via
// bit slips, monitors invalid headers while locked, and gates checker valid.
module baser_257b_lock_ctrl #(
  parameter int LOCK_CNT  = 64,
  parameter int WIN_CNT   = 1024,
  parameter int INV_LIMIT = 16,
  parameter int SLIP_WAIT = 4,
  parameter int CNT_W     = 11
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_blk_valid,
  input  logic        i_sh,
  input  logic [3:0]  i_hdr_nib,
  output logic        o_chk_valid,
  output logic        o_block_lock,
  output logic        o_slip,
  output logic [31:0] o_slip_count,
  output logic [31:0] o_lock_loss_count,
  output logic [1:0]  o_state
);

  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [CNT_W-1:0]  LOCK_C    = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0]  WIN_C     = CNT_W'(WIN_CNT);
  localparam logic [CNT_W-1:0]  INV_C     = CNT_W'(INV_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  typedef enum logic [1:0] {
    ST_UNLOCK    = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;
  logic [CNT_W-1:0]  inv_cnt_q, inv_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              lock_q, lock_d;
  logic              slip_q, slip_d;
  logic [31:0]       slip_cnt_q, slip_cnt_d;
  logic [31:0]       loss_cnt_q, loss_cnt_d;

  logic              blk_invalid;
  logic [CNT_W-1:0]  blk_inc;
  logic [CNT_W-1:0]  inv_inc;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // A block is bad only when the sync header says control and all four flags are set.
  assign blk_invalid = ~i_sh & (&i_hdr_nib);
  assign blk_inc     = blk_cnt_q + CNT_ONE;
  assign inv_inc     = inv_cnt_q + CNT_W'(blk_invalid);

  always_comb begin
    state_d    = state_q;
    blk_cnt_d  = blk_cnt_q;
    inv_cnt_d  = inv_cnt_q;
    wait_cnt_d = wait_cnt_q;
    lock_d     = lock_q;
    slip_d     = 1'b0;
    slip_cnt_d = slip_cnt_q;
    loss_cnt_d = loss_cnt_q;

    case (state_q)
      ST_UNLOCK: begin
        lock_d = 1'b0;
        if (i_blk_valid) begin
          if (blk_invalid) begin
            state_d    = ST_SLIP_WAIT;
            slip_d     = 1'b1;
            slip_cnt_d = sat_inc(slip_cnt_q);
            blk_cnt_d  = '0;
            inv_cnt_d  = '0;
            wait_cnt_d = '0;
          end else if (blk_inc == LOCK_C) begin
            state_d   = ST_LOCKED;
            lock_d    = 1'b1;
            blk_cnt_d = '0;
            inv_cnt_d = '0;
          end else begin
            blk_cnt_d = blk_inc;
          end
        end
      end

      // Gearbox output is unsettled right after a slip, so blocks are ignored.
      ST_SLIP_WAIT: begin
        lock_d = 1'b0;
        if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ST_UNLOCK;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end

      ST_LOCKED: begin
        if (i_blk_valid) begin
          if (inv_inc == INV_C) begin
            state_d    = ST_SLIP_WAIT;
            lock_d     = 1'b0;
            slip_d     = 1'b1;
            slip_cnt_d = sat_inc(slip_cnt_q);
            loss_cnt_d = sat_inc(loss_cnt_q);
            blk_cnt_d  = '0;
            inv_cnt_d  = '0;
            wait_cnt_d = '0;
          end else if (blk_inc == WIN_C) begin
            blk_cnt_d = '0;
            inv_cnt_d = '0;
          end else begin
            blk_cnt_d = blk_inc;
            inv_cnt_d = inv_inc;
          end
        end
      end

      default: begin
        state_d    = ST_UNLOCK;
        lock_d     = 1'b0;
        blk_cnt_d  = '0;
        inv_cnt_d  = '0;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_UNLOCK;
      blk_cnt_q  <= '0;
      inv_cnt_q  <= '0;
      wait_cnt_q <= '0;
      lock_q     <= 1'b0;
      slip_q     <= 1'b0;
      slip_cnt_q <= '0;
      loss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      blk_cnt_q  <= blk_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      lock_q     <= lock_d;
      slip_q     <= slip_d;
      slip_cnt_q <= slip_cnt_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  // Combinational so the gate lines up with the block data going to the checker.
  assign o_chk_valid       = i_blk_valid & lock_q & i_rst_n;
  assign o_block_lock      = lock_q;
  assign o_slip            = slip_q;
  assign o_slip_count      = slip_cnt_q;
  assign o_lock_loss_count = loss_cnt_q;
  assign o_state           = state_q;

endmodule

// File: tb/tb_baser_257b_lock_ctrl.sv
// Directed bench for baser_257b_lock_ctrl: lock acquisition, slip timing,
// window-based lock loss, priority at the window edge and mid-run reset.
module tb_baser_257b_lock_ctrl;

  logic        clk;
  logic        i_rst_n;
  logic        i_blk_valid;
  logic        i_sh;
  logic [3:0]  i_hdr_nib;
  logic        o_chk_valid;
  logic        o_block_lock;
  logic        o_slip;
  logic [31:0] o_slip_count;
  logic [31:0] o_lock_loss_count;
  logic [1:0]  o_state;

  int n_checks;
  int n_errors;
  int fwd_cnt;
  int slip_seen;
  logic chkv_last;

  baser_257b_lock_ctrl dut (
    .clk               (clk),
    .i_rst_n           (i_rst_n),
    .i_blk_valid       (i_blk_valid),
    .i_sh              (i_sh),
    .i_hdr_nib         (i_hdr_nib),
    .o_chk_valid       (o_chk_valid),
    .o_block_lock      (o_block_lock),
    .o_slip            (o_slip),
    .o_slip_count      (o_slip_count),
    .o_lock_loss_count (o_lock_loss_count),
    .o_state           (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (o_slip === 1'b1) slip_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one cycle of input, capture the gated valid mid-cycle, step past the edge.
  task automatic drive(input logic v, input logic sh, input logic [3:0] nib);
    i_blk_valid = v;
    i_sh        = sh;
    i_hdr_nib   = nib;
    #1;
    chkv_last = o_chk_valid;
    if (o_chk_valid === 1'b1) fwd_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic good_blk(input int k);
    logic [3:0] nib;
    nib = 4'(k);
    if (nib == 4'hF) nib = 4'h7;
    if (k % 3 == 0) drive(1'b1, 1'b1, 4'hF);
    else            drive(1'b1, 1'b0, nib);
  endtask

  task automatic bad_blk();
    drive(1'b1, 1'b0, 4'hF);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    fwd_cnt   = 0;
    slip_seen = 0;
    chkv_last = 1'b0;
    i_rst_n     = 1'b0;
    i_blk_valid = 1'b1;
    i_sh        = 1'b1;
    i_hdr_nib   = 4'h0;

    #2;
    chk("rst_lock",  {31'd0, o_block_lock}, 32'd0);
    chk("rst_slip",  {31'd0, o_slip}, 32'd0);
    chk("rst_chkv",  {31'd0, o_chk_valid}, 32'd0);
    chk("rst_state", {30'd0, o_state}, 32'd0);
    chk("rst_slipcnt", o_slip_count, 32'd0);
    chk("rst_losscnt", o_lock_loss_count, 32'd0);
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;

    // Acquire lock with 64 good blocks.
    for (int k = 0; k < 63; k++) drive(1'b1, 1'b1, 4'h0);
    chk("lock_after63", {31'd0, o_block_lock}, 32'd0);
    drive(1'b1, 1'b1, 4'h0);
    chk("blk64_not_fwd", {31'd0, chkv_last}, 32'd0);
    chk("lock_after64", {31'd0, o_block_lock}, 32'd1);
    chk("state_locked", {30'd0, o_state}, 32'd2);
    chk("no_slip_acq", slip_seen, 32'd0);
    chk("slipcnt_acq", o_slip_count, 32'd0);

    // Two windows with 15 invalid blocks each: lock must hold.
    for (int w = 0; w < 2; w++) begin
      fwd_cnt = 0;
      for (int i = 0; i < 1024; i++) begin
        if (i < 15 * 64 && i % 64 == 0) bad_blk();
        else good_blk(i);
        if (w == 0 && i == 0) chk("blk65_fwd", {31'd0, chkv_last}, 32'd1);
      end
      chk("win15_lock", {31'd0, o_block_lock}, 32'd1);
      chk("win15_loss", o_lock_loss_count, 32'd0);
      chk("win15_fwd", fwd_cnt, 32'd1024);
    end

    // Third window: 16th invalid at block 151 drops lock.
    for (int i = 0; i <= 150; i++) begin
      if (i % 10 == 0) bad_blk();
      else good_blk(i);
    end
    chk("loss_blk_fwd", {31'd0, chkv_last}, 32'd1);
    chk("loss_lock", {31'd0, o_block_lock}, 32'd0);
    chk("loss_state", {30'd0, o_state}, 32'd1);
    chk("loss_slip", {31'd0, o_slip}, 32'd1);
    chk("loss_slipcnt", o_slip_count, 32'd1);
    chk("loss_losscnt", o_lock_loss_count, 32'd1);

    // Slip wait: state 1 for four cycles in total, blocks offered meanwhile are ignored.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 4'h0);
      chk("wait_state", {30'd0, o_state}, 32'd1);
      chk("wait_slip_low", {31'd0, o_slip}, 32'd0);
    end
    drive(1'b1, 1'b1, 4'h0);
    chk("wait_done", {30'd0, o_state}, 32'd0);
    chk("slip_one_cycle", slip_seen, 32'd1);

    for (int k = 0; k < 60; k++) good_blk(k);
    chk("wait_blks_ignored", {31'd0, o_block_lock}, 32'd0);

    // Invalid block while unlocked.
    bad_blk();
    chk("ul_slip", {31'd0, o_slip}, 32'd1);
    chk("ul_state", {30'd0, o_state}, 32'd1);
    chk("ul_slipcnt", o_slip_count, 32'd2);
    for (int c = 0; c < 3; c++) drive(1'b0, 1'b0, 4'hF);
    chk("ul_wait_state", {30'd0, o_state}, 32'd1);
    drive(1'b0, 1'b0, 4'hF);
    chk("ul_wait_done", {30'd0, o_state}, 32'd0);
    chk("ul_slip_seen", slip_seen, 32'd2);

    // Fresh 64 needed; idle cycles interleaved must not count.
    for (int k = 0; k < 63; k++) begin
      good_blk(k);
      if (k % 8 == 7) drive(1'b0, 1'b0, 4'hF);
    end
    chk("relock_63", {31'd0, o_block_lock}, 32'd0);
    good_blk(1);
    chk("relock_64", {31'd0, o_block_lock}, 32'd1);

    // 16th invalid on block 1024 of the window: lock loss wins over window clear.
    fwd_cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      if (i == 1023) chk("prio_pre_lock", {31'd0, o_block_lock}, 32'd1);
      if (i < 15 || i == 1023) bad_blk();
      else good_blk(i);
    end
    chk("prio_lock", {31'd0, o_block_lock}, 32'd0);
    chk("prio_loss", o_lock_loss_count, 32'd2);
    chk("prio_slipcnt", o_slip_count, 32'd3);
    chk("prio_fwd", fwd_cnt, 32'd1024);

    // Reset during the slip pulse.
    i_blk_valid = 1'b1;
    i_rst_n = 1'b0;
    #1;
    chk("mrst_slip", {31'd0, o_slip}, 32'd0);
    chk("mrst_state", {30'd0, o_state}, 32'd0);
    chk("mrst_slipcnt", o_slip_count, 32'd0);
    chk("mrst_losscnt", o_lock_loss_count, 32'd0);
    chk("mrst_chkv", {31'd0, o_chk_valid}, 32'd0);
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    for (int k = 0; k < 64; k++) good_blk(k);
    chk("mrst_relock", {31'd0, o_block_lock}, 32'd1);

    // Reset while locked.
    i_blk_valid = 1'b1;
    i_rst_n = 1'b0;
    #1;
    chk("lrst_lock", {31'd0, o_block_lock}, 32'd0);
    chk("lrst_chkv", {31'd0, o_chk_valid}, 32'd0);
    chk("lrst_state", {30'd0, o_state}, 32'd0);
    @(posedge clk);
    #1;
    i_rst_n = 1'b1;
    for (int k = 0; k < 64; k++) drive(1'b1, 1'b1, 4'h0);
    chk("lrst_relock", {31'd0, o_block_lock}, 32'd1);
    chk("final_slip_seen", slip_seen, 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
